// File: rtl/word_serializer_mod5.sv
// Parallel-to-serial feeder for the residue-mod-5 Mealy stage: clear pulse, then MSB-first frame.
// Build with CHECK_EN defined to add a CHECK state comparing res_in against a locally computed residue.
module word_serializer_mod5 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             clr_n,
  input  logic [2:0]       res_in,
  output logic             chk_done,
  output logic             chk_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  // Handshake: a word is taken at a rising edge where in_valid and in_ready are both high;
  // in_ready stays low from that edge until the frame (and check, if built) has completed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
`ifdef CHECK_EN
    SHIFT = 2'd2,
    CHECK = 2'd3
`else
    SHIFT = 2'd2
`endif
  } state_t;

  state_t state, state_next;
  logic   accept;

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             ready_q;
  logic             clr_q;
  logic             out_q;
  logic             valid_q;
  logic             last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && ready_q) begin
          accept     = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: state_next = SHIFT;
      SHIFT: begin
`ifdef CHECK_EN
        if (cnt == '0) state_next = CHECK;
`else
        if (cnt == '0) state_next = IDLE;
`endif
      end
`ifdef CHECK_EN
      CHECK: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

`ifdef CHECK_EN
  logic [2:0] res_q;
  logic       done_q;
  logic       err_q;

  // 2r+b is at most 9, so a single conditional subtract keeps the residue in 0..4.
  function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
    logic [3:0] v;
    v = {r, b};
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction
`else
  logic unused_res;
  assign unused_res = ^res_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg    <= '0;
      cnt     <= '0;
      ready_q <= 1'b1;
      clr_q   <= 1'b1;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef CHECK_EN
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef CHECK_EN
      done_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            sreg    <= in_data;
            ready_q <= 1'b0;
            clr_q   <= 1'b0;
          end
        end
        CLEAR: begin
          clr_q   <= 1'b1;
          out_q   <= sreg[WIDTH-1];
          sreg    <= {sreg[WIDTH-2:0], 1'b0};
          valid_q <= 1'b1;
          last_q  <= 1'b0;
          cnt     <= CNT_MAX;
`ifdef CHECK_EN
          res_q   <= '0;
`endif
        end
        SHIFT: begin
`ifdef CHECK_EN
          res_q <= mod5_step(res_q, out_q);
`endif
          if (cnt == '0) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            out_q   <= 1'b0;
`ifndef CHECK_EN
            ready_q <= 1'b1;
`endif
          end else begin
            out_q  <= sreg[WIDTH-1];
            sreg   <= {sreg[WIDTH-2:0], 1'b0};
            cnt    <= cnt - CW'(1);
            last_q <= (cnt == CW'(1));
          end
        end
`ifdef CHECK_EN
        CHECK: begin
          done_q  <= 1'b1;
          err_q   <= (res_in != res_q);
          ready_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign clr_n     = clr_q;
  assign ser_out   = out_q;
  assign ser_valid = valid_q;
  assign ser_last  = last_q;
`ifdef CHECK_EN
  assign chk_done  = done_q;
  assign chk_err   = err_q;
`else
  assign chk_done  = 1'b0;
  assign chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_word_serializer_mod5.sv
// Directed bench for word_serializer_mod5 (WIDTH=8): vector table of words plus reset and back-to-back sequences.
module tb_word_serializer_mod5;
  localparam int W = 8;
`ifdef CHECK_EN
  localparam int GAP = W + 3;
`else
  localparam int GAP = W + 2;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         clr_n;
  logic [2:0]   res_in;
  logic         chk_done;
  logic         chk_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] word;
    logic [2:0]   res;
    logic         exp_err;
  } vec_t;
  vec_t vecs[6];

  word_serializer_mod5 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last), .clr_n(clr_n),
    .res_in(res_in), .chk_done(chk_done), .chk_err(chk_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40 && in_ready !== 1'b1; k++) tick();
    check("wait_ready", in_ready, 1);
  endtask

  // Sends one word and checks clear pulse, every frame bit and the tail; in_valid/in_data are disturbed mid-frame.
  task automatic run_frame(input logic [W-1:0] word, input logic [2:0] res, input logic exp_err);
    wait_ready();
    in_data  = word;
    in_valid = 1'b1;
    res_in   = 3'd0;
    tick();
    in_valid = 1'b0;
    in_data  = ~word;
    check("clear_clr_n", clr_n, 0);
    check("clear_ready", in_ready, 0);
    check("clear_valid", ser_valid, 0);
    tick();
    for (int i = 0; i < W; i++) begin
      check("bit_valid", ser_valid, 1);
      check("bit_value", ser_out, word[W-1-i]);
      check("bit_last", ser_last, (i == W - 1) ? 1 : 0);
      check("bit_clr_n", clr_n, 1);
      in_valid = (i < W - 1) ? i[0] : 1'b0;
      in_data  = W'($urandom);
      tick();
    end
    check("tail_valid", ser_valid, 0);
    check("tail_out", ser_out, 0);
    check("tail_last", ser_last, 0);
`ifdef CHECK_EN
    check("check_ready", in_ready, 0);
    res_in = res;
    tick();
    check("chk_done", chk_done, 1);
    check("chk_err", chk_err, exp_err);
    check("post_ready", in_ready, 1);
    tick();
    check("chk_done_pulse", chk_done, 0);
    check("chk_err_held", chk_err, exp_err);
    check("no_extra_frame", ser_valid, 0);
`else
    check("post_ready", in_ready, 1);
    check("chk_done_tied", chk_done, 0);
    check("chk_err_tied", chk_err, 0);
    tick();
    check("no_extra_frame", ser_valid, 0);
    check("idle_ready", in_ready, 1);
    if (res == 3'd7 && exp_err) $display("unused vector fields");
`endif
  endtask

  initial begin
    int   t1;
    int   t2;
    logic rdy;

    vecs[0] = '{word: 8'd13,  res: 3'd3, exp_err: 1'b0};
    vecs[1] = '{word: 8'hFF,  res: 3'd1, exp_err: 1'b1};
    vecs[2] = '{word: 8'd5,   res: 3'd0, exp_err: 1'b0};
    vecs[3] = '{word: 8'h80,  res: 3'd3, exp_err: 1'b0};
    vecs[4] = '{word: 8'h01,  res: 3'd1, exp_err: 1'b0};
    vecs[5] = '{word: 8'hA5,  res: 3'd2, exp_err: 1'b1};

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    res_in   = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_clr_n", clr_n, 1);
    check("rst_out", ser_out, 0);
    check("rst_valid", ser_valid, 0);
    check("rst_last", ser_last, 0);
    check("rst_chk_done", chk_done, 0);
    check("rst_chk_err", chk_err, 0);
    rst = 1'b1;
    tick();
    check("idle_hold_valid", ser_valid, 0);

    for (int v = 0; v < 6; v++) run_frame(vecs[v].word, vecs[v].res, vecs[v].exp_err);

    // Back-to-back: in_valid held high across two words.
    wait_ready();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int k = 0; k < 40 && t2 < 0; k++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        if (t1 < 0) begin
          t1 = k;
          in_data = 8'h3C;
        end else begin
          t2 = k;
        end
      end
    end
    in_valid = 1'b0;
    check("b2b_gap", t2 - t1, GAP);
    wait_ready();

    // Reset asserted during the third SHIFT cycle.
    in_data  = 8'h96;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_valid", ser_valid, 1);
    rst = 1'b0;
    #1;
    check("arst_valid", ser_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_clr_n", clr_n, 1);
    check("arst_out", ser_out, 0);
    check("arst_last", ser_last, 0);
    check("arst_chk_err", chk_err, 0);
    rst = 1'b1;
    tick();
    check("no_resume", ser_valid, 0);
    run_frame(8'h6B, 3'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
